mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of the instruction/data memory arbiter.
// master = the arbiter itself, slave = the requesters and memory around it.
interface mem_arbiter_if;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic        i_ready;
  logic        d_ready;
  logic [31:0] imemload;
  logic [31:0] dmmload;
  logic        bus_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  modport master (
    input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, mem_rdata, mem_busy,
    output i_ready, d_ready, imemload, dmmload, bus_err,
    output mem_ren, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, mem_rdata, mem_busy,
    input  i_ready, d_ready, imemload, dmmload, bus_err,
    input  mem_ren, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-source (instruction/data) arbiter onto a single memory port with
// alternating priority under contention and a busy-wait timeout abort.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               last_d, last_d_n;
  logic               ren_q, ren_n;
  logic               wen_q, wen_n;
  logic [31:0]        addr_q, addr_n;
  logic [31:0]        wdata_q, wdata_n;
  logic [31:0]        iload_q, iload_n;
  logic [31:0]        dload_q, dload_n;
  logic               irdy_q, irdy_n;
  logic               drdy_q, drdy_n;
  logic               err_q, err_n;

  logic               d_req;
  logic               pick_d;
  logic               pick_wr;
  logic               done;
  logic [31:0]        rd_val;

  // Data wins a tie unless it was the previous grant; both-strobes counts as a write.
  assign d_req   = bus.dmmRen | bus.dmmWen;
  assign pick_d  = d_req & (~bus.imemRen | ~last_d);
  assign pick_wr = pick_d & bus.dmmWen;
  assign done    = ~bus.mem_busy | (cnt == CNT_W'(TIMEOUT));
  assign rd_val  = bus.mem_busy ? 32'h0 : bus.mem_rdata;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_d_n = last_d;
    ren_n    = ren_q;
    wen_n    = wen_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    iload_n  = iload_q;
    dload_n  = dload_q;
    irdy_n   = 1'b0;
    drdy_n   = 1'b0;
    err_n    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.imemRen | d_req) begin
          state_n  = pick_d ? DBUS : IBUS;
          last_d_n = pick_d;
          cnt_n    = '0;
          addr_n   = pick_d ? bus.dmmaddr : bus.imemaddr;
          wdata_n  = pick_wr ? bus.dmmstore : 32'h0;
          wen_n    = pick_wr;
          ren_n    = ~pick_wr;
        end
      end
      IBUS, DBUS: begin
        if (done) begin
          // A timeout completes like a normal access but flags the error and returns zero.
          state_n = RESP;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          err_n   = bus.mem_busy;
          if (state == IBUS) begin
            irdy_n  = 1'b1;
            iload_n = rd_val;
          end else begin
            drdy_n = 1'b1;
            if (!wen_q) dload_n = rd_val;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      last_d  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      iload_q <= 32'h0;
      dload_q <= 32'h0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last_d  <= last_d_n;
      ren_q   <= ren_n;
      wen_q   <= wen_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      iload_q <= iload_n;
      dload_q <= dload_n;
      irdy_q  <= irdy_n;
      drdy_q  <= drdy_n;
      err_q   <= err_n;
    end
  end

  assign bus.mem_ren   = ren_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.imemload  = iload_q;
  assign bus.dmmload   = dload_q;
  assign bus.i_ready   = irdy_q;
  assign bus.d_ready   = drdy_q;
  assign bus.bus_err   = err_q;

endmodule
